// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: data RAM, sub-word loads, latency stall FSM, MEM/WB register
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_RegWrite,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemToReg,
  input  logic [1:0]  in_load_mode,
  input  logic [4:0]  in_writebackDestination,
  input  logic [31:0] in_aluResult,
  input  logic [31:0] in_rt,
  input  logic [31:0] in_pc,
  input  logic        in_zero,
  output logic        stall_out,
  output logic [31:0] pc_out,
  output logic        zero_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [4:0]  writebackDestination_out,
  output logic [31:0] aluResult_out,
  output logic [31:0] memData_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  // The IDLE cycle that accepts an access is itself the first cycle of the
  // access, so the counter only has to cover the remaining BUSY cycles
  // before the completing one.
  localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        access;
  logic        stall;
  logic        complete;
  logic        ram_we;

  logic [31:0]       ram_q [0:(1 << ADDR_W) - 1];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic [4:0]  wb_dest_q;
  logic [31:0] alu_result_q;
  logic [31:0] mem_data_q;

  assign access  = in_MemRead | in_MemWrite;
  assign idx     = in_aluResult[ADDR_W+1:2];
  assign rd_word = ram_q[idx];
  assign ram_we  = complete & in_MemWrite & ~rst;

  // Access sequencing: decides stall and the cycle on which the access completes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !rst) begin
          if (MEM_LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
            stall   = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and remaining-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word store on the completing edge; a store interrupted by reset is dropped
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[idx] <= in_rt;
    end
  end

  // Little-endian sub-word selection and extension for loads
  always_comb begin
    rd_byte   = 8'd0;
    rd_half   = 16'd0;
    load_data = 32'd0;
    case (in_aluResult[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = in_aluResult[1] ? rd_word[31:16] : rd_word[15:0];
    if (in_MemRead && !in_MemWrite) begin
      case (in_load_mode)
        2'b00:   load_data = rd_word;
        2'b01:   load_data = {{16{rd_half[15]}}, rd_half};
        2'b10:   load_data = {{24{rd_byte[7]}}, rd_byte};
        default: load_data = {24'd0, rd_byte};
      endcase
    end
  end

  // MEM/WB register: capture when not stalled, otherwise insert a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wb_dest_q    <= 5'd0;
      alu_result_q <= 32'd0;
      mem_data_q   <= 32'd0;
    end else if (!stall) begin
      reg_write_q  <= in_RegWrite;
      mem_to_reg_q <= in_MemToReg;
      wb_dest_q    <= in_writebackDestination;
      alu_result_q <= in_aluResult;
      mem_data_q   <= load_data;
    end else begin
      reg_write_q  <= 1'b0;
    end
  end

  assign stall_out                = stall;
  assign pc_out                   = in_pc;
  assign zero_out                 = in_zero;
  assign RegWrite_out             = reg_write_q;
  assign MemToReg_out             = mem_to_reg_q;
  assign writebackDestination_out = wb_dest_q;
  assign aluResult_out            = alu_result_q;
  assign memData_out              = mem_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage at latency 1 and latency 3
module tb_mem_stage;

  logic        clk;
  logic        rst_a, rst_b;
  logic        rw, mw, mr, m2r, zero;
  logic [1:0]  mode;
  logic [4:0]  dest;
  logic [31:0] alu, rt, pc;

  logic        a_stall, a_zero, a_rw, a_m2r;
  logic [31:0] a_pc, a_alu, a_mem;
  logic [4:0]  a_dest;
  logic        b_stall, b_zero, b_rw, b_m2r;
  logic [31:0] b_pc, b_alu, b_mem;
  logic [4:0]  b_dest;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.ADDR_W(8), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .in_RegWrite(rw), .in_MemWrite(mw), .in_MemRead(mr), .in_MemToReg(m2r),
    .in_load_mode(mode), .in_writebackDestination(dest), .in_aluResult(alu),
    .in_rt(rt), .in_pc(pc), .in_zero(zero),
    .stall_out(a_stall), .pc_out(a_pc), .zero_out(a_zero),
    .RegWrite_out(a_rw), .MemToReg_out(a_m2r), .writebackDestination_out(a_dest),
    .aluResult_out(a_alu), .memData_out(a_mem)
  );

  mem_stage #(.ADDR_W(8), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst_b),
    .in_RegWrite(rw), .in_MemWrite(mw), .in_MemRead(mr), .in_MemToReg(m2r),
    .in_load_mode(mode), .in_writebackDestination(dest), .in_aluResult(alu),
    .in_rt(rt), .in_pc(pc), .in_zero(zero),
    .stall_out(b_stall), .pc_out(b_pc), .zero_out(b_zero),
    .RegWrite_out(b_rw), .MemToReg_out(b_m2r), .writebackDestination_out(b_dest),
    .aluResult_out(b_alu), .memData_out(b_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic irw, input logic imw, input logic imr, input logic im2r,
                       input logic [1:0] imode, input logic [4:0] idest,
                       input logic [31:0] ialu, input logic [31:0] irt);
    rw = irw; mw = imw; mr = imr; m2r = im2r;
    mode = imode; dest = idest; alu = ialu; rt = irt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    pc    = 32'h0000_1000;
    zero  = 1'b1;
    drive(1, 0, 0, 1, 2'b00, 5'd7, 32'h55, 32'h0);
    tick();
    tick();

    // reset state, latency 1
    chk("rst_a_stall", 32'(a_stall), 32'd0);
    chk("rst_a_rw",    32'(a_rw),    32'd0);
    chk("rst_a_m2r",   32'(a_m2r),   32'd0);
    chk("rst_a_dest",  32'(a_dest),  32'd0);
    chk("rst_a_alu",   a_alu,        32'd0);
    chk("rst_a_mem",   a_mem,        32'd0);
    chk("rst_b_stall", 32'(b_stall), 32'd0);
    chk("pc_pass",     a_pc,         32'h0000_1000);
    chk("zero_pass",   32'(a_zero),  32'd1);

    rst_a = 1'b0;

    // sw 0xDEADBEEF -> 0x10, then lw 0x10
    drive(0, 1, 0, 0, 2'b00, 5'd0, 32'h10, 32'hDEAD_BEEF);
    #1 chk("sw_stall", 32'(a_stall), 32'd0);
    tick();
    chk("sw_rw",  32'(a_rw), 32'd0);
    chk("sw_mem", a_mem,     32'd0);
    chk("sw_alu", a_alu,     32'h10);

    drive(1, 0, 1, 1, 2'b00, 5'd5, 32'h10, 32'h0);
    #1 chk("lw_stall", 32'(a_stall), 32'd0);
    tick();
    chk("lw_mem",  a_mem,         32'hDEAD_BEEF);
    chk("lw_rw",   32'(a_rw),     32'd1);
    chk("lw_dest", 32'(a_dest),   32'd5);
    chk("lw_m2r",  32'(a_m2r),    32'd1);

    // sub-word loads from 0x8badf00d at 0x20
    drive(0, 1, 0, 0, 2'b00, 5'd0, 32'h20, 32'h8BAD_F00D);
    tick();
    drive(1, 0, 1, 1, 2'b10, 5'd2, 32'h21, 32'h0);
    tick();
    chk("lb_21", a_mem, 32'hFFFF_FFF0);
    drive(1, 0, 1, 1, 2'b11, 5'd2, 32'h21, 32'h0);
    tick();
    chk("lbu_21", a_mem, 32'h0000_00F0);
    drive(1, 0, 1, 1, 2'b01, 5'd2, 32'h22, 32'h0);
    tick();
    chk("lh_22", a_mem, 32'hFFFF_8BAD);
    drive(1, 0, 1, 1, 2'b01, 5'd2, 32'h20, 32'h0);
    tick();
    chk("lh_20", a_mem, 32'hFFFF_F00D);
    drive(1, 0, 1, 1, 2'b10, 5'd2, 32'h23, 32'h0);
    tick();
    chk("lb_23", a_mem, 32'hFFFF_FF8B);
    drive(1, 0, 1, 1, 2'b11, 5'd2, 32'h20, 32'h0);
    tick();
    chk("lbu_20", a_mem, 32'h0000_000D);
    drive(1, 0, 1, 1, 2'b00, 5'd2, 32'h23, 32'h0);
    tick();
    chk("lw_23", a_mem, 32'h8BAD_F00D);

    // R-type pass-through, destination 0 unchanged
    drive(1, 0, 0, 0, 2'b00, 5'd0, 32'h7, 32'h0);
    tick();
    chk("rt_alu",  a_alu,        32'h7);
    chk("rt_rw",   32'(a_rw),    32'd1);
    chk("rt_dest", 32'(a_dest),  32'd0);
    chk("rt_mem",  a_mem,        32'd0);
    chk("rt_m2r",  32'(a_m2r),   32'd0);

    // read/write conflict with address wrap, then read back
    drive(1, 1, 1, 1, 2'b00, 5'd3, 32'h404, 32'hA5);
    tick();
    chk("conf_mem", a_mem, 32'd0);
    drive(1, 0, 1, 1, 2'b00, 5'd3, 32'h4, 32'h0);
    tick();
    chk("wrap_lw", a_mem, 32'h0000_00A5);

    // latency 3
    rst_a = 1'b1;
    rst_b = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
    tick();

    drive(0, 1, 0, 0, 2'b00, 5'd0, 32'h40, 32'h5);
    #1 chk("l3_sw_c1_stall", 32'(b_stall), 32'd1);
    tick();
    chk("l3_sw_c2_stall", 32'(b_stall), 32'd1);
    tick();
    chk("l3_sw_c3_stall", 32'(b_stall), 32'd0);
    tick();

    drive(1, 0, 0, 0, 2'b00, 5'd1, 32'h2, 32'h0);
    #1 chk("l3_nop_stall", 32'(b_stall), 32'd0);
    tick();
    chk("l3_nop_rw", 32'(b_rw), 32'd1);

    drive(1, 0, 1, 1, 2'b00, 5'd9, 32'h40, 32'h0);
    #1 chk("l3_lw_c1_stall", 32'(b_stall), 32'd1);
    tick();
    chk("l3_lw_c2_stall", 32'(b_stall), 32'd1);
    chk("l3_bub1_rw",     32'(b_rw),    32'd0);
    chk("l3_bub1_alu",    b_alu,        32'h2);
    tick();
    chk("l3_lw_c3_stall", 32'(b_stall), 32'd0);
    chk("l3_bub2_rw",     32'(b_rw),    32'd0);
    tick();
    chk("l3_lw_mem",  b_mem,        32'h5);
    chk("l3_lw_rw",   32'(b_rw),    32'd1);
    chk("l3_lw_dest", 32'(b_dest),  32'd9);
    chk("l3_lw_alu",  b_alu,        32'h40);

    drive(1, 0, 0, 0, 2'b00, 5'd4, 32'h7, 32'h0);
    #1 chk("l3_rt_stall", 32'(b_stall), 32'd0);
    tick();
    chk("l3_rt_alu", b_alu,      32'h7);
    chk("l3_rt_rw",  32'(b_rw),  32'd1);
    chk("l3_rt_mem", b_mem,      32'd0);

    // reset in the second cycle of a store
    drive(0, 1, 0, 0, 2'b00, 5'd0, 32'h40, 32'h1234);
    #1 chk("l3_rsw_c1_stall", 32'(b_stall), 32'd1);
    tick();
    chk("l3_rsw_c2_stall", 32'(b_stall), 32'd1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
    #1 chk("l3_rst_stall", 32'(b_stall), 32'd0);
    chk("l3_rst_rw",  32'(b_rw),  32'd0);
    chk("l3_rst_alu", b_alu,      32'd0);
    chk("l3_rst_mem", b_mem,      32'd0);
    tick();

    drive(1, 0, 1, 1, 2'b00, 5'd6, 32'h40, 32'h0);
    #1 chk("l3_rlw_c1_stall", 32'(b_stall), 32'd1);
    tick();
    tick();
    chk("l3_rlw_c3_stall", 32'(b_stall), 32'd0);
    tick();
    chk("l3_rlw_mem",  b_mem,       32'h5);
    chk("l3_rlw_dest", 32'(b_dest), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
